// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: PC handshake, instruction-memory req/ack port,
// decode-side valid/ready port and the branch flush strobe.
// master = the fetch queue itself, slave = the surrounding PC/memory/decode.
interface fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_hold;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              ins_valid;
  logic              ins_ready;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_addr;
  logic              flush;

  modport master (
    input  pc_addr, flush, mem_ack, mem_data, ins_ready,
    output pc_hold, mem_req, mem_addr, ins_valid, ins_data, ins_addr
  );

  modport slave (
    output pc_addr, flush, mem_ack, mem_data, ins_ready,
    input  pc_hold, mem_req, mem_addr, ins_valid, ins_data, ins_addr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: takes the PC address, fetches it over a
// variable-latency req/ack port (one request in flight) and buffers the
// returned word, tagged with its address, in a small FIFO towards decode.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no request outstanding; launches when FIFO has room
// ST_WAIT | request outstanding, returned word will be pushed
// ST_DROP | request outstanding after a flush, returned word discarded
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              mem_req_next;
  logic [ADDR_W-1:0] mem_addr_next;

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic launch;
  logic ack;
  logic push;
  logic pop;

  // An ack only counts while a request is actually outstanding.
  assign ack    = bus.mem_req & bus.mem_ack;
  // Room is checked at launch time, so the eventual push always fits.
  assign launch = (state == ST_IDLE) && (count < DEPTH_CNT) && !bus.flush && !rst;
  assign bus.pc_hold = !launch;

  assign bus.ins_valid = (count != '0);
  assign bus.ins_data  = data_mem[rd_ptr];
  assign bus.ins_addr  = addr_mem[rd_ptr];
  assign pop           = bus.ins_valid & bus.ins_ready;

  // Next-state, request and push decode.
  always_comb begin
    state_next    = state;
    mem_req_next  = bus.mem_req;
    mem_addr_next = bus.mem_addr;
    push          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          mem_req_next  = 1'b1;
          mem_addr_next = bus.pc_addr;
          state_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack) begin
          push         = !bus.flush;
          mem_req_next = 1'b0;
          state_next   = ST_IDLE;
        end else if (bus.flush) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (ack) begin
          mem_req_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        mem_req_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // State and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      state        <= state_next;
      bus.mem_req  <= mem_req_next;
      bus.mem_addr <= mem_addr_next;
    end
  end

  // FIFO occupancy and pointers; flush empties the queue and drops that cycle's push/pop.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr] <= bus.mem_addr;
      data_mem[wr_ptr] <= bus.mem_data;
    end
  end

endmodule
